// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
//   Shared definitions for the sequential integer divider:
//     - 2-bit divide opcode encodings as seen on op_i
//     - FSM state encoding
//     - reset polarity
//     - small opcode decode helpers
// -----------------------------------------------------------------------------
package div_seq_pkg;

  // Reset is synchronous; this is the level that resets.
  localparam logic RstEnable = 1'b1;

  // op_i: bit1 = signed, bit0 = remainder select
  localparam logic [1:0] EXE_DIVU_OP = 2'b00;
  localparam logic [1:0] EXE_MODU_OP = 2'b01;
  localparam logic [1:0] EXE_DIV_OP  = 2'b10;
  localparam logic [1:0] EXE_MOD_OP  = 2'b11;

  // State encodings
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_FIX_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } div_state_e;

  // Iteration counter width; holds 0..WIDTH-1 for WIDTH up to 63.
  localparam int CNT_W = 6;

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   {rem, quo} is shifted left by one, the divisor is trial-subtracted from the
//   widened partial remainder and the difference is kept when it does not go
//   negative; the shifted-in quotient bit records whether it was kept.
//   Chaining two instances gives a radix-4 step.
//
//   Ports:
//     rem      in   WIDTH  partial remainder (always < divisor when divisor != 0)
//     quo      in   WIDTH  dividend bits still to shift / quotient bits so far
//     divisor  in   WIDTH  magnitude of the divisor
//     rem_next out  WIDTH  partial remainder after this step
//     quo_next out  WIDTH  quotient/dividend register after this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // One extra bit so the shifted remainder never overflows.
    rem_shift = {rem, quo[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, divisor});
    // When the subtraction is kept its result is below the divisor, so the
    // low WIDTH bits are the whole answer.
    diff      = rem_shift[WIDTH-1:0] - divisor;
    rem_next  = fits ? diff : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//   Multi-cycle 32-bit integer DIV/MOD sequencer (signed and unsigned) for the
//   execute stage. One restoring step per cycle; the pipeline is stalled while
//   the divider runs and the result is returned with a one-cycle valid pulse.
//
//   Latency: request accepted at cycle T, valid_o at T+WIDTH+2.
//
//   Build option:
//     DIV_ZERO_FAST_EN  defined: zero divisor skips the iterations (IDLE->FIX),
//                       valid_o at T+2. Results are identical either way.
//
//   Ports:
//     clk         in   1      rising-edge clock
//     rst         in   1      synchronous active-high reset
//     flush       in   1      abort any operation, no result is produced
//     start_i     in   1      divide request present in EX
//     op_i        in   2      bit1 signed, bit0 remainder select
//     dividend_i  in   WIDTH  rj operand
//     divisor_i   in   WIDTH  rk operand
//     ready_o     out  1      idle, a request will be accepted
//     stall_o     out  1      hold IF..EX this cycle
//     valid_o     out  1      result_o valid (one-cycle pulse)
//     result_o    out  WIDTH  quotient or remainder
// -----------------------------------------------------------------------------
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] result_reg;
  logic             rem_sel_reg;
  logic             neg_quo_reg;
  logic             neg_rem_reg;
  logic             div_zero_reg;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             divisor_zero;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] fix_value;

  // ---------------------------------------------------------------------------
  // Operand preparation at accept. Unsigned ops pass the raw operands; the
  // magnitude of the most negative value is itself as an unsigned number,
  // which makes MIN / -1 come out as MIN with remainder 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_neg        = op_is_signed(op_i) & dividend_i[WIDTH-1];
    b_neg        = op_is_signed(op_i) & divisor_i[WIDTH-1];
    a_abs        = a_neg ? -dividend_i : dividend_i;
    b_abs        = b_neg ? -divisor_i : divisor_i;
    divisor_zero = (divisor_i == '0);
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    accept     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i && !flush) begin
          accept  = 1'b1;
          stall_o = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          state_next = divisor_zero ? ST_FIX : ST_CALC;
`else
          state_next = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        stall_o = 1'b1;
        if (count_reg == LAST_CNT) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        stall_o    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        // stall_o low here lets EX retire with the result this cycle.
        valid_o    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction and result select (evaluated in FIX).
  // Quotient negates when operand signs differ; remainder follows the dividend.
  // A zero divisor forces all-ones for DIV and the raw dividend for MOD.
  // ---------------------------------------------------------------------------
  always_comb begin
    quo_fix = neg_quo_reg ? -quo_reg : quo_reg;
    rem_fix = neg_rem_reg ? -rem_reg : rem_reg;
    if (div_zero_reg) begin
      fix_value = rem_sel_reg ? dividend_reg : {WIDTH{1'b1}};
    end else begin
      fix_value = rem_sel_reg ? rem_fix : quo_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_reg    <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      result_reg   <= '0;
      rem_sel_reg  <= 1'b0;
      neg_quo_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      if (accept) begin
        count_reg    <= '0;
        rem_reg      <= '0;
        quo_reg      <= a_abs;
        divisor_reg  <= b_abs;
        dividend_reg <= dividend_i;
        rem_sel_reg  <= op_is_rem(op_i);
        neg_quo_reg  <= a_neg ^ b_neg;
        neg_rem_reg  <= a_neg;
        div_zero_reg <= divisor_zero;
      end else if (state_reg == ST_CALC) begin
        rem_reg   <= step_rem;
        quo_reg   <= step_quo;
        count_reg <= count_reg + 1'b1;
      end

      // A flush in FIX leaves the previous result visible.
      if (state_reg == ST_FIX && !flush) begin
        result_reg <= fix_value;
      end
    end
  end

  assign result_o = result_reg;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle integer divide sequencer for the execution stage. It takes DIV/MOD requests (signed and unsigned, 32-bit) from EX and runs a one-bit-per-cycle restoring divider. While the divider runs, it stalls the pipeline, and it returns the quotient or remainder with a one-cycle valid pulse. It replaces the single-cycle `/` and `%` arithmetic path, so the divide no longer sits on EX's critical path.

## Interface
Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; aborts any operation
- start_i  in  1  request valid from EX (divide op present in EX)
- op_i  in  2  bit1 = signed, bit0 = remainder select; 00 DIV.WU, 01 MOD.WU, 10 DIV.W, 11 MOD.W
- dividend_i  in  WIDTH  rj operand
- divisor_i  in  WIDTH  rk operand
- ready_o  out  1  sequencer idle, request will be accepted
- stall_o  out  1  hold IF..EX this cycle
- valid_o  out  1  result_o valid, one-cycle pulse
- result_o  out  WIDTH  quotient or remainder

## Operation
- States:
  - IDLE: ready_o=1.
  - CALC: runs the iterations.
  - FIX: sign correction and result select.
  - DONE: valid_o=1.
- Transitions:
  - IDLE→CALC on start_i & ~flush. Capture op_i, the sign bits, |dividend|, |divisor| (unsigned ops use the raw operands), and clear the 6-bit count.
  - CALC loops for WIDTH cycles. Each cycle performs one restoring step: shift {rem, quo} left by 1, trial-subtract the divisor, keep the result if it is non-negative, and set the quotient bit.
  - CALC→FIX when count reaches WIDTH-1.
  - FIX→DONE: register result_o.
  - DONE→IDLE unconditionally.
- Arithmetic rules:
  - Truncation toward zero.
  - Quotient is negated when the signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000 and remainder 0, which falls out of the abs-value path with no special case.
- Divide by zero: result is 0xFFFFFFFF for DIV and dividend_i for MOD, for both signed and unsigned ops. FIX forces these values.
- Request rules:
  - start_i is ignored when state ≠ IDLE.
  - EX holds its inputs while stall_o=1.
- Flush and reset:
  - flush in any state → IDLE next cycle; no valid_o pulse; result_o is unchanged.
  - flush coincident with start_i: the request is dropped.
  - rst overrides flush and start_i.
- Reset values: state IDLE, valid_o 0, result_o 0, count 0. This yields ready_o 1 and stall_o = start_i.

## Timing
- Request sampled at edge of cycle T.
  - CALC occupies T+1..T+WIDTH.
  - FIX is T+WIDTH+1.
  - DONE (valid_o=1) is T+WIDTH+2, i.e. T+34 for WIDTH=32.
- stall_o = (IDLE & start_i & ~flush) | CALC | FIX. It is combinational, low in DONE so EX retires with the result that cycle.
- ready_o = (state==IDLE), combinational.
- Back-to-back divides: the next op enters EX at T+35 with the sequencer already IDLE, so there are no bubbles beyond the latency.

## Configuration
- DIV_ZERO_FAST_EN defined: a zero divisor detected at accept goes IDLE→FIX directly, so valid_o arrives at T+2.
- Undefined: a zero divisor runs the full WIDTH iterations. Result values are identical in both builds.

## Structure
- Shared defines/package:
  - op_i encodings (EXE_DIV_OP, EXE_MOD_OP, EXE_DIVU_OP, EXE_MODU_OP mapped to the 2-bit op)
  - state encoding localparams
  - RstEnable polarity
- Sub-module div_step (combinational): one restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - This allows a later radix-4 build by instantiating two steps.

## Test plan
- DIV.WU 100 / 7, start at T → stall_o high T..T+33, valid_o at T+34, result_o 14; MOD.WU gives 2.
- DIV.W -7 / 2 → 0xFFFFFFFD (-3); MOD.W -7 / 2 → 0xFFFFFFFF (-1); MOD.W 7 / -2 → 1.
- DIV.W 0x80000000 / 0xFFFFFFFF → 0x80000000; MOD.W same operands → 0.
- DIV.WU 5 / 0 → 0xFFFFFFFF; MOD.W -5 / 0 → 0xFFFFFFFB. valid_o at T+34, or at T+2 with DIV_ZERO_FAST_EN.
- flush at T+10 → IDLE at T+11, no valid_o pulse. A new start at T+11 is accepted and completes at T+45 with the correct result.
- start_i asserted during CALC with different operands → ignored; the in-flight result is unchanged. rst at T+5 → IDLE, valid_o 0, result_o 0 next cycle.
